n_serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes diff = a - b - b_in, one bit per clock, LSB first. It is the inverse-direction companion to the team's n_ripple_adder: same operand width, and borrow-in/borrow-out in place of carry-in/carry-out. It trades the ripple chain for a single 1-bit full-subtractor cell plus shift registers, with a start/busy/done handshake for use by sequential datapath control.

---
 rtl/n_serial_subtractor_pkg.sv | 13 +
 rtl/n_serial_subtractor_full_subtractor.sv | 13 +
 rtl/n_serial_subtractor.sv | 106 ++++++++++
 tb/tb_n_serial_subtractor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/n_serial_subtractor_pkg.sv
// Shared constants and state encodings for the serial subtractor family.
// The width default is shared with n_ripple_adder and its bench.
package n_serial_subtractor_pkg;

  localparam int unsigned N_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/n_serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - b_i, with borrow-out b_o.
module full_subtractor (
  output logic d,
  output logic b_o,
  input  logic x,
  input  logic y,
  input  logic b_i
);

  assign d   = x ^ y ^ b_i;
  assign b_o = (~x & y) | (~(x ^ y) & b_i);

endmodule

// File: rtl/n_serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, LSB first, one bit per clock,
// with a start/busy/done handshake.
module n_serial_subtractor
  import n_serial_subtractor_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         busy,
  output logic         done
);

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-1:0]  r_res_sr;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_diff;
  logic          r_b_out;
  logic          w_d;
  logic          w_b_o;
  logic          w_last;

  full_subtractor u_cell (
    .d   (w_d),
    .b_o (w_b_o),
    .x   (r_a_sr[0]),
    .y   (r_b_sr[0]),
    .b_i (r_br)
  );

  assign w_last = (r_cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the unused code 3 falls back to IDLE
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next_state = w_last ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture, bit stepping and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_b_out  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_br     <= b_in;
            r_cnt    <= '0;
            r_res_sr <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= {w_d, r_res_sr[N-1:1]};
          r_br     <= w_b_o;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff  <= {w_d, r_res_sr[N-1:1]};
            r_b_out <= w_b_o;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff  = r_diff;
  assign b_out = r_b_out;
  assign busy  = (r_state == ST_SHIFT);
  assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_n_serial_subtractor.sv
// Scoreboard bench for n_serial_subtractor at N=5 and N=8 sharing one stimulus stream.
module tb_n_serial_subtractor;
  import n_serial_subtractor_pkg::*;

  localparam int unsigned N0 = N_DEFAULT;
  localparam int unsigned N1 = 8;

  typedef struct {
    logic [7:0] diff;
    logic       bo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    a = '0;
  logic [7:0]    b = '0;
  logic          b_in = 1'b0;
  logic [N0-1:0] diff0;
  logic          bo0, busy0, done0;
  logic [N1-1:0] diff1;
  logic          bo1, busy1, done1;

  int   cyc = 0;
  int   acc [2] = '{-1, -1};
  int   nw  [2] = '{int'(N0), int'(N1)};
  logic [7:0] last_diff [2] = '{8'd0, 8'd0};
  logic       last_bo   [2] = '{1'b0, 1'b0};
  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  n_serial_subtractor #(.N(N0), .CW(3)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a[N0-1:0]), .b(b[N0-1:0]), .b_in(b_in),
    .diff(diff0), .b_out(bo0), .busy(busy0), .done(done0)
  );

  n_serial_subtractor #(.N(N1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
    .diff(diff1), .b_out(bo1), .busy(busy1), .done(done1)
  );

  function automatic exp_t ref_sub(int w, logic [7:0] x, logic [7:0] y, logic bi);
    exp_t e;
    int   mask;
    int   r;
    mask = (1 << w) - 1;
    r    = (int'(x) & mask) - (int'(y) & mask) - int'(bi);
    e.bo   = (r < 0);
    e.diff = 8'(r & mask);
    return e;
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  // Reference model: acceptance timing and expected results
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        acc[k]       = -1;
        last_diff[k] = '0;
        last_bo[k]   = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else if (start && (acc[k] < 0 || cyc >= acc[k] + nw[k] + 2)) begin
        acc[k] = cyc;
        if (k == 0) q0.push_back(ref_sub(nw[k], a, b, b_in));
        else        q1.push_back(ref_sub(nw[k], a, b, b_in));
      end
    end
  end

  task automatic mon(int k, logic bz, logic dn, logic [7:0] df, logic bo);
    logic eb, ed;
    exp_t e;
    eb = (acc[k] >= 0) && (cyc >= acc[k]) && (cyc < acc[k] + nw[k]);
    ed = (acc[k] >= 0) && (cyc == acc[k] + nw[k]);
    check("busy", k, 32'(bz), 32'(eb));
    check("done", k, 32'(dn), 32'(ed));
    if (dn === 1'b1) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_without_op dut%0d cycle %0d: got done=1 expected no pending op", k, cyc);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        last_diff[k] = e.diff;
        last_bo[k]   = e.bo;
      end
    end
    check("diff", k, 32'(df), 32'(last_diff[k]));
    check("b_out", k, 32'(bo), 32'(last_bo[k]));
  endtask

  // Monitor: samples on the falling edge
  always @(negedge clk) begin
    mon(0, busy0, done0, 8'(diff0), bo0);
    mon(1, busy1, done1, diff1, bo1);
  end

  task automatic drive(logic s, logic [7:0] aa, logic [7:0] bb, logic bi);
    @(negedge clk);
    start = s;
    a     = aa;
    b     = bb;
    b_in  = bi;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic op(logic [7:0] aa, logic [7:0] bb, logic bi);
    drive(1'b1, aa, bb, bi);
    idle(12);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    op(8'd13, 8'd6, 1'b0);
    op(8'd6, 8'd13, 1'b0);
    op(8'd0, 8'd0, 1'b1);
    op(8'd31, 8'd31, 1'b0);
    op(8'd255, 8'd0, 1'b1);

    // start held high with changing operands while busy
    drive(1'b1, 8'd20, 8'd3, 1'b0);
    for (int i = 0; i < 14; i++) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    idle(12);

    // reset after two shifts aborts the operation
    drive(1'b1, 8'd9, 8'd4, 1'b0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    op(8'd9, 8'd4, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      for (int j = 0; j < 9; j++)
        drive(1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    idle(15);

    check("pending_ops", 0, 32'(q0.size()), 32'd0);
    check("pending_ops", 1, 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
